dot_matrix_scan_ctrl: RTL and testbench
=======================================

// Module: dot_matrix_scan_ctrl
// PURPOSE
//   Row-scan sequencer for the 16x16 LED dot-matrix pattern ROMs.
//   - Steps row_bin 0..15 and selects one of NUM_PAT pattern ROMs (pat_sel); an external mux returns that row as col_in.
//   - Drives the matrix with a registered active-low one-hot row and the active-high column word.
//   - Blanks between rows to prevent ghosting.
//   - Advances the pattern on a button press or automatically, only at frame boundaries.
// PARAMETERS
//   DIV          50000  SCAN-phase length in clk cycles (row on-time)
//   BLANK_CYC    8      all-off cycles before each row
//   NUM_PAT      4      number of patterns; pat_sel wraps NUM_PAT-1 -> 0
//   HOLD_FRAMES  64     frames per pattern in auto mode
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   en           in   1   scan enable; low forces BLANK and holds row_bin
//   btn_next     in   1   raw push button; asynchronous, so synchronized internally
//   auto_en      in   1   auto-advance after HOLD_FRAMES frames
//   col_in       in   16  column word for (pat_sel,row_bin); combinational, from ROM mux
//   row_bin      out  4   row index to pattern ROMs
//   pat_sel      out  clog2(NUM_PAT)  pattern select
//   row_n        out  16  active-low one-hot row drive
//   col_out      out  16  column drive, active-high
//   frame_pulse  out  1   1-cycle pulse when row 15 finishes
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - Outputs: row_n=16'hFFFF, col_out=0, row_bin=0, pat_sel=0, frame_pulse=0.
//     - Internal: state=BLANK, all counters 0, pending advance cleared.
//     - Reset deassert mid-row restarts at row 0, pattern 0.
//   FSM BLANK -> LOAD -> SCAN -> BLANK
//     BLANK  row_n=FFFF, col_out=0 for BLANK_CYC cycles, then LOAD if en=1.
//     LOAD   1 cycle; row_bin stable; col_in captured into col_out reg.
//     SCAN   row_n[row_bin]=0 (all other bits 1), col_out held, for exactly DIV cycles.
//            On the last cycle, row_bin<=row_bin+1 (15 wraps to 0), then go to BLANK.
//   Timing and enable
//     - Row period = BLANK_CYC+1+DIV cycles; frame = 16 row periods.
//     - en=0 in any state: next cycle BLANK, outputs off, row_bin/pat_sel frozen.
//     - en=1 again: resume at the frozen row with a full BLANK.
//   Frame boundary (row 15 leaves SCAN)
//     - frame_pulse=1 for 1 cycle; frame_cnt++.
//     - frame_cnt wraps at HOLD_FRAMES-1 -> 0 and sets the auto request if auto_en=1.
//   Pattern advance
//     - btn_next: 2-FF synchronizer, rising-edge detect; sets the pending flag.
//     - At a frame boundary, if pending or auto request: pat_sel+1 (wraps), pending cleared, frame_cnt=0.
//     - Multiple presses within one frame, or press plus auto at the same boundary, advance by exactly 1.
//     - A press on the boundary cycle itself counts toward the next boundary.
//     - pat_sel never changes mid-frame, so frames do not tear.
//   Widths: counters sized by clog2 of each parameter; no truncation of DIV.
// CONFIGURATION
//   SCROLL_EN defined
//     - 4-bit scroll offset, incremented at each frame boundary, wraps 15 -> 0.
//     - Reset, or a pattern change, clears it to 0.
//     - Captured col_out = col_in rotated left by offset.
//   SCROLL_EN undefined: no offset register; col_out = col_in exactly.
// STRUCTURE
//   - Shared package dm_pkg: ROWS=16, COLS=16, row_bin width 4, state encoding {BLANK,LOAD,SCAN}.
//   - One sub-module dm_btn_sync: 2-FF synchronizer plus rising-edge pulse, reset to 0.
//   - All other logic in this module.
// TESTING  (DIV=4, BLANK_CYC=2, NUM_PAT=4, HOLD_FRAMES=2)
//   1 Reset then en=1, col_in=16'h0810 -> 2 cycles FFFF/0; LOAD; then 4 cycles row_n=FFFE, col_out=0810; row_bin=1.
//   2 Run 16 rows -> row_bin 15->0, frame_pulse exactly 1 cycle, each row_n pattern one-hot low.
//   3 btn_next pulsed 3x in frame 0 -> pat_sel 0->1 only at frame boundary, no change mid-frame.
//   4 auto_en=1 and no button -> pat_sel increments every 2 frames; 3->0 wrap; btn+auto on same boundary -> +1 only.
//   5 en=0 during SCAN of row 5 -> next cycle row_n=FFFF, col_out=0; en=1 -> BLANK, then row 5 rescanned.
//   6 rst_n=0 mid-SCAN -> outputs immediately FFFF/0, row_bin=0, pat_sel=0.
//     SCROLL_EN: col_in=0001, frame 3 -> col_out=0008.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and helpers for the 16x16 dot-matrix row-scan controller.
package dm_pkg;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int ROW_W = 4;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2
  } dm_state_e;

  // Active-low one-hot drive for a single row.
  function automatic logic [ROWS-1:0] row_onehot_n(input logic [ROW_W-1:0] r);
    return ~(16'h0001 << r);
  endfunction

  // Rotate a column word left; the doubled word keeps the wrap-around bits.
  function automatic logic [COLS-1:0] rotl_cols(input logic [COLS-1:0] v,
                                                input logic [3:0]      sh);
    logic [2*COLS-1:0] d;
    d = {v, v} << sh;
    return d[2*COLS-1:COLS];
  endfunction

endpackage

// File: rtl/dot_matrix_scan_ctrl_if.sv
// Pattern-ROM and matrix-drive bundle between the scan controller and its surroundings.
interface dot_matrix_scan_ctrl_if #(
  parameter int PAT_W = 2
);
  import dm_pkg::*;

  logic [ROW_W-1:0] row_bin;
  logic [PAT_W-1:0] pat_sel;
  logic [COLS-1:0]  col_in;
  logic [ROWS-1:0]  row_n;
  logic [COLS-1:0]  col_out;
  logic             frame_pulse;

  modport master (
    output row_bin, pat_sel, row_n, col_out, frame_pulse,
    input  col_in
  );

  modport slave (
    input  row_bin, pat_sel, row_n, col_out, frame_pulse,
    output col_in
  );

endinterface

// File: rtl/dm_btn_sync.sv
// Two-flop synchronizer for the raw push button with a registered rising-edge pulse.
module dm_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic rise_r;

  // Synchronize and edge-detect the button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      rise_r  <= sync2_r & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/dot_matrix_scan_ctrl.sv
// Row-scan sequencer for 16x16 LED pattern ROMs with blanking and frame-aligned pattern advance.
// Optional SCROLL_EN build adds a per-frame rotating column offset.
module dot_matrix_scan_ctrl
  import dm_pkg::*;
#(
  parameter int DIV         = 50000,
  parameter int BLANK_CYC   = 8,
  parameter int NUM_PAT     = 4,
  parameter int HOLD_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    btn_next,
  input  logic                    auto_en,
  dot_matrix_scan_ctrl_if.master  mx
);

  localparam int PAT_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam int DIV_W  = $clog2(DIV + 1);
  localparam int BLK_W  = $clog2(BLANK_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  dm_state_e        state_r;
  logic [BLK_W-1:0] blank_cnt_r;
  logic [DIV_W-1:0] scan_cnt_r;
  logic [ROW_W-1:0] row_bin_r;
  logic [PAT_W-1:0] pat_sel_r;
  logic [ROWS-1:0]  row_n_r;
  logic [COLS-1:0]  col_out_r;
  logic             frame_pulse_r;
  logic [HOLD_W-1:0] frame_cnt_r;
  logic             pending_r;

  logic             btn_rise_s;
  logic             scan_last_s;
  logic             boundary_s;
  logic             hold_wrap_s;
  logic             advance_s;
  logic [PAT_W-1:0] next_pat_s;
  logic [COLS-1:0]  cap_s;

  dm_btn_sync u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .rise  (btn_rise_s)
  );

  assign scan_last_s = (scan_cnt_r == DIV_W'(DIV - 1));
  assign boundary_s  = en && (state_r == ST_SCAN) && scan_last_s && (row_bin_r == 4'd15);
  assign hold_wrap_s = (frame_cnt_r == HOLD_W'(HOLD_FRAMES - 1));
  assign advance_s   = pending_r || (hold_wrap_s && auto_en);
  assign next_pat_s  = (pat_sel_r == PAT_W'(NUM_PAT - 1)) ? {PAT_W{1'b0}} : pat_sel_r + PAT_W'(1);

`ifdef SCROLL_EN
  logic [3:0] offset_r;
  assign cap_s = rotl_cols(mx.col_in, offset_r);
`else
  assign cap_s = mx.col_in;
`endif

  // Scan FSM: blanking, column capture and row on-time, with registered matrix drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BLANK;
      blank_cnt_r   <= {BLK_W{1'b0}};
      scan_cnt_r    <= {DIV_W{1'b0}};
      row_bin_r     <= 4'd0;
      row_n_r       <= 16'hFFFF;
      col_out_r     <= 16'h0000;
      frame_pulse_r <= 1'b0;
    end else begin
      frame_pulse_r <= 1'b0;
      if (!en) begin
        state_r     <= ST_BLANK;
        blank_cnt_r <= {BLK_W{1'b0}};
        scan_cnt_r  <= {DIV_W{1'b0}};
        row_n_r     <= 16'hFFFF;
        col_out_r   <= 16'h0000;
      end else begin
        case (state_r)
          ST_BLANK: begin
            if (blank_cnt_r == BLK_W'(BLANK_CYC - 1)) begin
              state_r     <= ST_LOAD;
              blank_cnt_r <= {BLK_W{1'b0}};
            end else begin
              blank_cnt_r <= blank_cnt_r + BLK_W'(1);
            end
          end
          ST_LOAD: begin
            state_r    <= ST_SCAN;
            scan_cnt_r <= {DIV_W{1'b0}};
            row_n_r    <= row_onehot_n(row_bin_r);
            col_out_r  <= cap_s;
          end
          ST_SCAN: begin
            if (scan_last_s) begin
              state_r       <= ST_BLANK;
              scan_cnt_r    <= {DIV_W{1'b0}};
              row_n_r       <= 16'hFFFF;
              col_out_r     <= 16'h0000;
              row_bin_r     <= row_bin_r + 4'd1;
              frame_pulse_r <= (row_bin_r == 4'd15);
            end else begin
              scan_cnt_r <= scan_cnt_r + DIV_W'(1);
            end
          end
          default: begin
            state_r     <= ST_BLANK;
            blank_cnt_r <= {BLK_W{1'b0}};
            scan_cnt_r  <= {DIV_W{1'b0}};
            row_n_r     <= 16'hFFFF;
            col_out_r   <= 16'h0000;
          end
        endcase
      end
    end
  end

  // Frame-aligned pattern advance: a press on the boundary cycle itself is kept for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_sel_r   <= {PAT_W{1'b0}};
      frame_cnt_r <= {HOLD_W{1'b0}};
      pending_r   <= 1'b0;
`ifdef SCROLL_EN
      offset_r    <= 4'd0;
`endif
    end else if (boundary_s) begin
      pending_r <= btn_rise_s;
      if (advance_s) begin
        pat_sel_r   <= next_pat_s;
        frame_cnt_r <= {HOLD_W{1'b0}};
`ifdef SCROLL_EN
        offset_r    <= 4'd0;
`endif
      end else begin
        frame_cnt_r <= hold_wrap_s ? {HOLD_W{1'b0}} : frame_cnt_r + HOLD_W'(1);
`ifdef SCROLL_EN
        offset_r    <= offset_r + 4'd1;
`endif
      end
    end else if (btn_rise_s) begin
      pending_r <= 1'b1;
    end
  end

  assign mx.row_bin     = row_bin_r;
  assign mx.pat_sel     = pat_sel_r;
  assign mx.row_n       = row_n_r;
  assign mx.col_out     = col_out_r;
  assign mx.frame_pulse = frame_pulse_r;

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Randomized self-checking bench for dot_matrix_scan_ctrl against a row-period position model.
module tb_dot_matrix_scan_ctrl;

  localparam int DIV    = 4;
  localparam int BLANK  = 2;
  localparam int NP     = 4;
  localparam int HOLD   = 2;
  localparam int PERIOD = BLANK + 1 + DIV;
  localparam int NCYC   = 3200;

  logic clk;
  logic rst_n;
  logic en;
  logic btn_next;
  logic auto_en;

  dot_matrix_scan_ctrl_if #(.PAT_W(2)) dmi ();

  dot_matrix_scan_ctrl #(
    .DIV(DIV), .BLANK_CYC(BLANK), .NUM_PAT(NP), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .btn_next (btn_next),
    .auto_en  (auto_en),
    .mx       (dmi)
  );

  function automatic logic [15:0] rom(input int pat, input int row);
    return 16'((pat * 16'h3B1D) ^ (row * 16'h0107) ^ 16'h8421 ^ (row << 12));
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  // ROM mux outside the controller
  assign dmi.col_in = rom(int'(dmi.pat_sel), int'(dmi.row_bin));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Model: p = cycle position inside the current row period (0..BLANK-1 blank, BLANK load, rest scan)
  int p, mrow, mpat, mfc, moff;
  bit mpend, mfp;
  logic [15:0] mcap;

  task automatic model_reset();
    p = 0; mrow = 0; mpat = 0; mfc = 0; moff = 0;
    mpend = 1'b0; mfp = 1'b0; mcap = 16'h0000;
  endtask

  task automatic frame_end(input bit a);
    bit adv;
    mfp = 1'b1;
    adv = mpend;
    mfc++;
    if (mfc == HOLD) begin
      mfc = 0;
      if (a) adv = 1'b1;
    end
`ifdef SCROLL_EN
    moff = (moff + 1) % 16;
`endif
    if (adv) begin
      mpat  = (mpat + 1) % NP;
      mfc   = 0;
      moff  = 0;
      mpend = 1'b0;
    end
  endtask

  task automatic model_step(input bit e, input bit a);
    mfp = 1'b0;
    if (!e) begin
      p = 0;
    end else begin
      if (p == BLANK) mcap = rotl(rom(mpat, mrow), moff);
      p++;
      if (p == PERIOD) begin
        p = 0;
        if (mrow == 15) frame_end(a);
        mrow = (mrow + 1) % 16;
      end
    end
  endtask

  task automatic check_outputs();
    logic [15:0] er, ec;
    if (p > BLANK) begin
      er = 16'hFFFF ^ (16'd1 << mrow);
      ec = mcap;
    end else begin
      er = 16'hFFFF;
      ec = 16'h0000;
    end
    chk("row_n", 32'(dmi.row_n), 32'(er));
    chk("col_out", 32'(dmi.col_out), 32'(ec));
    chk("row_bin", 32'(dmi.row_bin), 32'(mrow));
    chk("pat_sel", 32'(dmi.pat_sel), 32'(mpat));
    chk("frame_pulse", 32'(dmi.frame_pulse), 32'(mfp));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_row_n"}, 32'(dmi.row_n), 32'h0000FFFF);
    chk({tag, "_col_out"}, 32'(dmi.col_out), 32'h0);
    chk({tag, "_row_bin"}, 32'(dmi.row_bin), 32'h0);
    chk({tag, "_pat_sel"}, 32'(dmi.pat_sel), 32'h0);
    chk({tag, "_frame_pulse"}, 32'(dmi.frame_pulse), 32'h0);
  endtask

  initial begin
    int btn_timer;
    int en_low;
    bit did_rst;
    int frames;
    n_chk = 0; n_pass = 0;
    btn_timer = 0; en_low = 0; did_rst = 1'b0; frames = 0;
    rst_n = 1'b1; en = 1'b0; btn_next = 1'b0; auto_en = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    #2 rst_n = 1'b1;
    model_step(1'b0, auto_en);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (mfp) frames++;

      // Asynchronous reset in the middle of a scan phase
      if (!did_rst && cyc >= 1600 && btn_timer == 0 && en && p > BLANK + 1) begin
        did_rst = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_state("midscan_rst");
        en = 1'b0; btn_next = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_state("rst_held");
        #2 rst_n = 1'b1;
        model_step(1'b0, auto_en);
        continue;
      end

      // Button presses only mid-frame, so every press lands well before its boundary
      if (btn_timer > 0) begin
        btn_timer--;
      end else if (mrow >= 2 && mrow <= 10 && $urandom_range(0, 39) == 0) begin
        btn_timer = 6;
        mpend = 1'b1;
      end
      btn_next = (btn_timer > 3);

      if (en_low > 0) begin
        en_low--;
        en = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        en_low = $urandom_range(0, 5);
        en = 1'b0;
      end else begin
        en = 1'b1;
      end

      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;

      model_step(en, auto_en);
    end

    chk("frames_seen_nonzero", 32'(frames > 8), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
